// File: rtl/uart_block_rx.sv
// 8N1 UART receiver that packs 16 consecutive good bytes into one 128-bit AES block.
// First byte on the wire lands in o_block[0:7]; partial blocks time out when the line goes quiet.
module uart_block_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 1_000_000
) (
    input  logic         sys_clk_i,
    input  logic         sys_rstn_i,
    input  logic         uart_rx,
    output logic [7:0]   o_byte,
    output logic         o_byte_valid,
    output logic         o_frame_err,
    output logic [4:0]   o_byte_count,
    output logic [0:127] o_block,
    output logic         o_block_valid,
    output logic         o_busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int TW   = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic [TW-1:0] tout_cnt;
    logic [7:0]    shadow [0:14];

    // The line idles high, so the synchroniser resets to 1 to avoid a false start bit.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rstn_i) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            tout_cnt      <= '0;
            o_byte        <= '0;
            o_byte_valid  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_byte_count  <= '0;
            o_block       <= '0;
            o_block_valid <= 1'b0;
            for (int k = 0; k < 15; k++) shadow[k] <= '0;
        end else begin
            o_byte_valid  <= 1'b0;
            o_frame_err   <= 1'b0;
            o_block_valid <= 1'b0;

            // Timeout runs only between frames; the STOP branch below overrides it.
            if (o_byte_count == 5'd0) begin
                tout_cnt <= '0;
            end else if (state == IDLE) begin
                if (tout_cnt == TOUT_LAST) begin
                    tout_cnt     <= '0;
                    o_byte_count <= '0;
                end else begin
                    tout_cnt <= tout_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        // Back to IDLE mid stop bit so an immediate next start edge is caught.
                        bit_cnt  <= '0;
                        state    <= IDLE;
                        tout_cnt <= '0;
                        if (rx_s) begin
                            o_byte       <= shift_reg;
                            o_byte_valid <= 1'b1;
                            if (o_byte_count == 5'd15) begin
                                for (int k = 0; k < 15; k++) o_block[8*k +: 8] <= shadow[k];
                                o_block[120 +: 8] <= shift_reg;
                                o_block_valid     <= 1'b1;
                                o_byte_count      <= '0;
                            end else begin
                                shadow[o_byte_count[3:0]] <= shift_reg;
                                o_byte_count              <= o_byte_count + 5'd1;
                            end
                        end else begin
                            o_frame_err  <= 1'b1;
                            o_byte_count <= '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
